// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding constants for the wide-move encoder.
// Provides:
//   - MOVZ/MOVK 9-bit opcode fields (instruction bits [31:23])
//   - halfword-select codes HW_0..HW_3 (instruction bits [22:21])
//   - FSM state encoding used by movwide_encoder
//   - encode_mov(): packs opc9/hw/imm16/Rd into a 32-bit instruction
package legv8_pkg;

  localparam logic [8:0] MOVZ_OPC = 9'b110100101;
  localparam logic [8:0] MOVK_OPC = 9'b111100101;

  localparam logic [1:0] HW_0 = 2'd0;
  localparam logic [1:0] HW_1 = 2'd1;
  localparam logic [1:0] HW_2 = 2'd2;
  localparam logic [1:0] HW_3 = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // Field layout mirrors the decoder's MOVZ immediate extraction.
  function automatic logic [31:0] encode_mov(input logic [8:0]  opc,
                                             input logic [1:0]  hw,
                                             input logic [15:0] imm,
                                             input logic [4:0]  rd);
    return {opc, hw, imm, rd};
  endfunction

endpackage

// File: rtl/movwide_encoder_if.sv
// Bundle of the request/response handshake signals of movwide_encoder.
// Ports (as modport views):
//   master: drives the request side (in_valid, Const64, Rd) and out_ready
//   slave : the encoder's view (drives in_ready, out_valid, Instr, out_last)
interface movwide_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] Const64;
  logic [4:0]  Rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Instr;
  logic        out_last;

  modport master (output in_valid, Const64, Rd, out_ready,
                  input  in_ready, out_valid, Instr, out_last);

  modport slave  (input  in_valid, Const64, Rd, out_ready,
                  output in_ready, out_valid, Instr, out_last);
endinterface

// File: rtl/movwide_encoder_hw_pick.sv
// Lowest-set-bit priority encoder over the 4-bit halfword mask.
// Ports:
//   mask  : halfwords still to be emitted
//   idx   : hw code of the lowest set bit (HW_0 when nothing is set)
//   found : at least one bit of mask is set
module hw_pick
  import legv8_pkg::*;
(
  input  logic [3:0] mask,
  output logic [1:0] idx,
  output logic       found
);

  always_comb begin
    idx   = HW_0;
    found = 1'b1;
    casez (mask)
      4'b???1: idx = HW_0;
      4'b??10: idx = HW_1;
      4'b?100: idx = HW_2;
      4'b1000: idx = HW_3;
      default: begin
        idx   = HW_0;
        found = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/movwide_encoder.sv
// Turns a 64-bit constant into a MOVZ followed by zero to three MOVKs,
// one instruction per output handshake, skipping all-zero halfwords.
// Ports:
//   CLK, Reset_L          : clock, asynchronous active-low reset
//   in_valid/in_ready     : request handshake carrying Const64 and Rd
//   out_valid/out_ready   : instruction handshake carrying Instr, out_last
module movwide_encoder
  import legv8_pkg::*;
(
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] Const64,
  input  logic [4:0]  Rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Instr,
  output logic        out_last
);

  state_e      state_q, state_d;
  logic [63:0] const_q, const_d;
  logic [4:0]  rd_q, rd_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] instr_q, instr_d;
  logic        last_q, last_d;
  logic        valid_q, valid_d;
  // Held low through reset so in_ready only rises on the first edge after release.
  logic        alive_q, alive_d;

  logic [3:0]  new_mask;
  logic [3:0]  src_mask;
  logic [3:0]  rest_mask;
  logic [63:0] src_const;
  logic [4:0]  src_rd;
  logic [1:0]  pick_idx;
  logic        pick_found;
  logic [15:0] pick_imm;
  logic [31:0] next_instr;

  // In IDLE the picker looks at the incoming constant so the first
  // instruction is ready the cycle after acceptance; in EMIT it looks at
  // the halfwords not yet emitted.
  hw_pick u_hw_pick (
    .mask  (src_mask),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      new_mask[k] = |Const64[16*k +: 16];
    end

    src_mask  = (state_q == ST_IDLE) ? new_mask : mask_q;
    src_const = (state_q == ST_IDLE) ? Const64  : const_q;
    src_rd    = (state_q == ST_IDLE) ? Rd       : rd_q;

    rest_mask = pick_found ? (src_mask & ~(4'b0001 << pick_idx)) : 4'b0000;
    // With an empty mask pick_idx is HW_0 and that halfword is zero,
    // which yields the required MOVZ #0.
    pick_imm  = src_const[{pick_idx, 4'b0000} +: 16];
    next_instr = encode_mov((state_q == ST_IDLE) ? MOVZ_OPC : MOVK_OPC,
                            pick_idx, pick_imm, src_rd);
  end

  always_comb begin
    state_d = state_q;
    const_d = const_q;
    rd_d    = rd_q;
    mask_d  = mask_q;
    instr_d = instr_q;
    last_d  = last_q;
    valid_d = valid_q;
    alive_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && alive_q) begin
          state_d = ST_EMIT;
          const_d = Const64;
          rd_d    = Rd;
          mask_d  = rest_mask;
          instr_d = next_instr;
          last_d  = (rest_mask == 4'b0000);
          valid_d = 1'b1;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = ST_IDLE;
            const_d = '0;
            rd_d    = '0;
            mask_d  = '0;
            instr_d = '0;
            last_d  = 1'b0;
            valid_d = 1'b0;
          end else begin
            mask_d  = rest_mask;
            instr_d = next_instr;
            last_d  = (rest_mask == 4'b0000);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= ST_IDLE;
      const_q <= '0;
      rd_q    <= '0;
      mask_q  <= '0;
      instr_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      const_q <= const_d;
      rd_q    <= rd_d;
      mask_q  <= mask_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      alive_q <= alive_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && alive_q;
  assign out_valid = valid_q;
  assign Instr     = instr_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_movwide_encoder.sv
// Scoreboard testbench for movwide_encoder: directed requests push their
// hand-computed instruction sequences into a queue; a monitor pops and
// compares on every output handshake.
module tb_movwide_encoder;

  typedef struct {
    logic [31:0] instr;
    logic        last;
  } exp_t;

  logic CLK;
  logic Reset_L;

  movwide_encoder_if bus ();

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  movwide_encoder dut (
    .CLK       (CLK),
    .Reset_L   (Reset_L),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .Const64   (bus.Const64),
    .Rd        (bus.Rd),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .Instr     (bus.Instr),
    .out_last  (bus.out_last)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Monitor: pops the scoreboard on every handshake, and checks that
  // idle outputs are zero.
  always @(negedge CLK) begin
    if (Reset_L && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_out: got Instr=%h last=%0b, expected nothing", bus.Instr, bus.out_last);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.Instr !== e.instr || bus.out_last !== e.last) begin
          errors++;
          $display("[TB] FAIL instr: got %h last=%0b, expected %h last=%0b", bus.Instr, bus.out_last, e.instr, e.last);
        end
      end
    end else if (!bus.out_valid) begin
      checks++;
      if (bus.Instr !== 32'h0 || bus.out_last !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_zero: got Instr=%h last=%0b, expected 0/0", bus.Instr, bus.out_last);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic pushExp(input logic [31:0] instr, input logic last);
    exp_t e;
    e.instr = instr;
    e.last  = last;
    sb.push_back(e);
  endtask

  // Issues one request; returns 1 ns after the accepting edge.
  task automatic applyStimulus(input logic [63:0] c, input logic [4:0] rd);
    int n;
    n = 0;
    @(negedge CLK);
    while (!bus.in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!bus.in_ready) begin
      errors++;
      $display("[TB] FAIL in_ready_timeout: got 0, expected 1");
    end
    bus.in_valid = 1'b1;
    bus.Const64  = c;
    bus.Rd       = rd;
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    bus.Const64  = '0;
    bus.Rd       = '0;
  endtask

  // Waits until the sequence drains, checking in_ready stays low meanwhile.
  task automatic checkOutput();
    int n;
    n = 0;
    while ((bus.out_valid || sb.size() != 0) && n < 60) begin
      if (bus.out_valid) check("in_ready_busy", {31'b0, bus.in_ready}, 32'h0);
      @(posedge CLK);
      #1;
      n++;
    end
    checks++;
    if (bus.out_valid || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
    check("in_ready_after", {31'b0, bus.in_ready}, 32'h1);
  endtask

  initial begin
    Reset_L       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.Const64   = '0;
    bus.Rd        = '0;
    bus.out_ready = 1'b1;

    #2;
    check("rst_in_ready",  {31'b0, bus.in_ready},  32'h0);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    check("rst_instr",     bus.Instr,              32'h0);
    #10;
    Reset_L = 1'b1;
    #1;
    check("in_ready_pre_edge", {31'b0, bus.in_ready}, 32'h0);
    @(posedge CLK);
    #1;
    check("in_ready_first_edge", {31'b0, bus.in_ready}, 32'h1);

    // All-zero constant
    pushExp(32'hD2800005, 1'b1);
    applyStimulus(64'h0, 5'd5);
    checkOutput();

    // Single low halfword
    pushExp(32'hD2824683, 1'b1);
    applyStimulus(64'h0000_0000_0000_1234, 5'd3);
    checkOutput();

    // Sparse halfwords
    pushExp(32'hD297DDE9, 1'b0);
    pushExp(32'hF2FBD5A9, 1'b1);
    applyStimulus(64'hDEAD_0000_0000_BEEF, 5'd9);
    checkOutput();

    // Single high halfword
    pushExp(32'hD2E00020, 1'b1);
    applyStimulus(64'h0001_0000_0000_0000, 5'd0);
    checkOutput();

    // Backpressure on the second instruction, with request noise during EMIT
    pushExp(32'hD2888881, 1'b0);
    pushExp(32'hF2A66661, 1'b0);
    pushExp(32'hF2C44441, 1'b0);
    pushExp(32'hF2E22221, 1'b1);
    bus.out_ready = 1'b0;
    applyStimulus(64'h1111_2222_3333_4444, 5'd1);
    bus.out_ready = 1'b1;
    @(posedge CLK);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.Const64   = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.Rd        = 5'd30;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check("stall_instr", bus.Instr, 32'hF2A66661);
      check("stall_valid", {31'b0, bus.out_valid}, 32'h1);
      check("stall_in_ready", {31'b0, bus.in_ready}, 32'h0);
    end
    bus.in_valid  = 1'b0;
    bus.Const64   = '0;
    bus.Rd        = '0;
    bus.out_ready = 1'b1;
    checkOutput();

    // Reset in the middle of a four-instruction sequence
    pushExp(32'hD2888881, 1'b0);
    bus.out_ready = 1'b0;
    applyStimulus(64'h1111_2222_3333_4444, 5'd1);
    bus.out_ready = 1'b1;
    @(posedge CLK);
    #1;
    bus.out_ready = 1'b0;
    check("mid_instr2", bus.Instr, 32'hF2A66661);
    #2;
    Reset_L = 1'b0;
    #1;
    check("mid_rst_valid",    {31'b0, bus.out_valid}, 32'h0);
    check("mid_rst_instr",    bus.Instr,              32'h0);
    check("mid_rst_in_ready", {31'b0, bus.in_ready},  32'h0);
    check("mid_rst_sb_empty", sb.size(), 32'h0);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #2;
    Reset_L = 1'b1;
    @(posedge CLK);
    #1;
    check("post_rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
    repeat (3) begin
      @(posedge CLK);
      #1;
      check("post_rst_quiet", {31'b0, bus.out_valid}, 32'h0);
    end

    // Fresh request after reset, Rd = 31 passes through
    pushExp(32'hD2CACF1F, 1'b1);
    applyStimulus(64'h0000_5678_0000_0000, 5'd31);
    checkOutput();

    check("sb_final_empty", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the sequencing above stalls.
  initial begin
    #20000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/movwide_encoder.md
MOVWIDE_ENCODER -- requirements
Module: movwide_encoder

Interface
REQ-001 SHALL have port CLK, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port Reset_L, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1: request carries a constant to encode.
REQ-004 SHALL have port in_ready, output, 1: block accepts a request this cycle.
REQ-005 SHALL have port Const64, input, 64: constant to be loaded into a register.
REQ-006 SHALL have port Rd, input, 5: destination register number; 31 is passed through unchanged.
REQ-007 SHALL have port out_valid, output, 1: Instr holds a valid instruction.
REQ-008 SHALL have port out_ready, input, 1: consumer takes Instr this cycle.
REQ-009 SHALL have port Instr, output, 32: encoded MOVZ/MOVK instruction.
REQ-010 SHALL have port out_last, output, 1: Instr is the final instruction of the current sequence.

Function
REQ-011 SHALL encode every instruction as opc9 in [31:23], hw in [22:21], imm16 in [20:5] and Rd in [4:0].
- MOVZ opc9 = 9'b110100101 (base 0xD2800000).
- MOVK opc9 = 9'b111100101 (base 0xF2800000).
- These field positions are the inverse of the decoder's MOVZ immediate extraction.
REQ-012 SHALL accept a request when in_valid && in_ready, capturing Const64 and Rd, and form a 4-bit nonzero-halfword mask (bit k = Const64[16k+15:16k] != 0).
REQ-013 SHALL implement the FSM IDLE -> EMIT -> IDLE.
- in_ready = 1 only in IDLE.
- The cycle after acceptance, the block is in EMIT with out_valid = 1, giving a latency of 1 cycle.
REQ-014 SHALL emit MOVZ at the lowest set mask index as the first instruction.
- If the mask is all-zero, that first instruction is MOVZ with hw = 0, imm16 = 0.
REQ-015 SHALL emit MOVK for each remaining set mask index as the following instructions, in ascending hw order, giving 1 to 4 instructions per request.
REQ-016 SHALL advance to the next instruction only on out_valid && out_ready.
- While out_valid && !out_ready, Instr and out_last are held stable.
REQ-017 SHALL assert out_last together with the final instruction of a sequence.
- A handshake on the last instruction returns the FSM to IDLE, and in_ready = 1 in the next cycle; there is no same-cycle re-accept.
REQ-018 SHALL ignore in_valid while in EMIT; Const64 and Rd changes during EMIT have no effect.
REQ-019 SHALL drive Instr = 0 and out_last = 0 whenever out_valid = 0.

Reset
REQ-020 SHALL force the following immediately on Reset_L = 0, independent of CLK:
- FSM = IDLE, out_valid = 0, out_last = 0, Instr = 0.
- Captured constant, Rd and mask cleared.
- in_ready = 0 while reset is asserted.
REQ-021 SHALL abandon any sequence interrupted by reset mid-EMIT, with no further instructions emitted.
- in_ready = 1 on the first CLK edge after Reset_L deasserts.

Structure
REQ-022 SHALL take the MOVZ/MOVK opc9 constants, hw codes 0-3 and FSM state encodings from the shared package legv8_pkg.
REQ-023 SHALL instantiate one sub-module, hw_pick, a 4-bit lowest-set-bit priority encoder that returns the index and a found flag from the remaining mask.
- Each handshake clears the mask bit just emitted.

Verification
REQ-024 SHALL verify all-zero input: Const64 = 0, Rd = 5 -> single Instr 0xD2800005 with out_last = 1.
REQ-025 SHALL verify a single low halfword: Const64 = 0x0000_0000_0000_1234, Rd = 3 -> single Instr 0xD2824683 with out_last = 1.
REQ-026 SHALL verify sparse halfwords: Const64 = 0xDEAD_0000_0000_BEEF, Rd = 9 -> 0xD297DDE9 (last = 0), then 0xF2FBD5A9 (last = 1).
REQ-027 SHALL verify a single high halfword: Const64 = 0x0001_0000_0000_0000, Rd = 0 -> single Instr 0xD2E00020 with out_last = 1.
REQ-028 SHALL verify backpressure: Const64 = 0x1111_2222_3333_4444, Rd = 1, out_ready held low 3 cycles on the 2nd instruction.
- Required response: 4 instructions in order hw 0, 1, 2, 3.
- Instr remains stable throughout the stall.
- in_ready = 0 until the cycle after the final handshake.
REQ-029 SHALL verify reset mid-sequence: Reset_L pulsed low during the 2nd of 4 instructions.
- out_valid = 0 immediately.
- No further instructions are emitted.
- in_ready = 1 after release.
- A new request then encodes correctly.
